ram_read_streamer: RTL and testbench
====================================

RAM_READ_STREAMER -- requirements
Module: ram_read_streamer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10: read address width in bits, matching the RAM read port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: read data width in bits, matching the RAM read port.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed in the next two lines.
REQ-004 clk  input  1  Single clock for all logic and the attached RAM read port.
REQ-005 resetn  input  1  Asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  Read command present.
REQ-007 cmd_ready  output  1  Command accepted when cmd_valid and cmd_ready are both high at a rising clk edge.
REQ-008 cmd_addr  input  ADDR_WIDTH  Word address to read.
REQ-009 ram_rd_en  output  1  Read enable to the RAM read port.
REQ-010 ram_rd_addr  output  ADDR_WIDTH  Address to the RAM read port.
REQ-011 ram_rd_data  input  DATA_WIDTH  RAM registered read data, valid in the cycle after ram_rd_en.
REQ-012 rsp_valid  output  1  Response data present.
REQ-013 rsp_ready  input  1  Response consumed when rsp_valid and rsp_ready are both high at a rising clk edge.
REQ-014 rsp_data  output  DATA_WIDTH  Read data, in command order.

Function
REQ-015 A command fire SHALL be cmd_valid && cmd_ready; ram_rd_en SHALL equal the command fire, and ram_rd_addr SHALL equal cmd_addr, combinationally.
REQ-016 A one-bit inflight register SHALL be set to the command fire value at every clk edge.
REQ-017 A 2-entry skid FIFO SHALL hold RAM data that could not be delivered in its arrival cycle; fifo_count SHALL range over 0..2.
REQ-018 rsp_valid SHALL be (fifo_count != 0) || inflight.
REQ-019 rsp_data SHALL be the FIFO head when fifo_count != 0, else ram_rd_data (bypass).
REQ-020 When inflight is high, ram_rd_data SHALL be pushed into the FIFO unless fifo_count == 0 and rsp_ready is high.
REQ-021 When fifo_count != 0 and rsp_ready is high, the FIFO head SHALL be popped; push and pop in the same cycle SHALL leave fifo_count unchanged.
REQ-022 Minimum latency SHALL be 1 cycle: a command fired at edge N SHALL give rsp_valid with its data in cycle N+1 when the FIFO is empty.
REQ-023 cmd_ready SHALL be high when (fifo_count + inflight) < 2, or when rsp_valid && rsp_ready; this combinational path from rsp_ready is intentional.
REQ-024 Sustained throughput SHALL be one response per cycle while cmd_valid and rsp_ready are held high.
REQ-025 Responses SHALL never be dropped, duplicated or reordered, and fifo_count + inflight SHALL never exceed 2.
REQ-026 While rsp_valid is high and rsp_ready is low, rsp_data SHALL remain stable.
REQ-027 The block SHALL NOT rely on the RAM holding its output when ram_rd_en is low.

Reset
REQ-028 While resetn is low: inflight = 0, fifo_count = 0, rsp_valid = 0, cmd_ready = 0, ram_rd_en = 0.
REQ-029 Reset assertion mid-operation SHALL discard in-flight and buffered data immediately.
REQ-030 The first command SHALL be acceptable at the first rising edge after resetn deasserts.
REQ-031 FIFO data storage SHALL need no reset.

Structure
REQ-032 The SKID_DEPTH = 2 constant SHALL live in the shared memory package; no new typedefs are required.
REQ-033 The skid FIFO SHALL be one sub-module, ram_read_skid_fifo, with push/pop/count/head ports.
REQ-034 Top-level glue SHALL be limited to the inflight register, ready logic and the bypass mux.

Verification
REQ-035 Single read: RAM preloaded with addr 5 = 0xDEADBEEF, rsp_ready = 1, one command to addr 5 -> rsp_valid exactly one cycle later with rsp_data = 0xDEADBEEF.
REQ-036 Streaming: addresses 0..15 back-to-back, rsp_ready = 1 -> 16 consecutive responses in order, one per cycle, cmd_ready never low.
REQ-037 Backpressure: rsp_ready = 0 while commands to addr 1, 2, 3 are offered -> exactly 2 accepted; cmd_ready low; rsp_data stable at data[1]; after rsp_ready = 1, outputs are data[1], data[2], data[3] in order.
REQ-038 Random stall: random cmd_valid/rsp_ready over 10k cycles against a scoreboard -> no loss, duplication or reordering; fifo_count + inflight <= 2 always.
REQ-039 Reset mid-stream: resetn pulsed low with fifo_count = 2 -> rsp_valid = 0 and cmd_ready = 0 asynchronously; after release, a fresh read returns the correct data with no stale responses.

Source files
------------

// File: rtl/ram_read_streamer_pkg.sv
// Shared memory-side constants for the RAM read streamer and its skid buffer.
package ram_read_streamer_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/ram_read_skid_fifo.sv
// Small skid FIFO catching RAM read data that cannot be delivered in its arrival cycle.
module ram_read_skid_fifo
  import ram_read_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = SKID_DEPTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [DATA_WIDTH-1:0]         head
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  // Data storage carries no reset; only the pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/ram_read_streamer.sv
// Turns a valid/ready read-command stream into an in-order valid/ready response
// stream from a RAM with a one-cycle registered read port.
module ram_read_streamer
  import ram_read_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  logic                  inflight_r;
  logic [SKID_CNT_W-1:0] fifo_count_s;
  logic [DATA_WIDTH-1:0] fifo_head_s;
  logic                  fifo_nonempty_s;
  logic                  fifo_push_s;
  logic                  fifo_pop_s;
  logic                  cmd_fire_s;
  logic                  cmd_ready_s;
  logic                  rsp_valid_s;
  logic [DATA_WIDTH-1:0] rsp_data_s;
  logic [SKID_CNT_W:0]   occupancy_s;

  // Ready, bypass mux and FIFO control; ready also opens when a response
  // leaves this cycle, so streaming runs at full rate.
  always_comb begin
    fifo_nonempty_s = (fifo_count_s != {SKID_CNT_W{1'b0}});
    occupancy_s     = {1'b0, fifo_count_s} + {{SKID_CNT_W{1'b0}}, inflight_r};
    rsp_valid_s     = fifo_nonempty_s || inflight_r;
    if (fifo_nonempty_s) begin
      rsp_data_s = fifo_head_s;
    end else begin
      rsp_data_s = ram_rd_data;
    end
    if (!resetn) begin
      cmd_ready_s = 1'b0;
    end else begin
      cmd_ready_s = (occupancy_s < (SKID_CNT_W+1)'(SKID_DEPTH)) || (rsp_valid_s && rsp_ready);
    end
    cmd_fire_s  = cmd_valid && cmd_ready_s;
    fifo_push_s = inflight_r && !(!fifo_nonempty_s && rsp_ready);
    fifo_pop_s  = fifo_nonempty_s && rsp_ready;
  end

  // One read is outstanding at the RAM when a command fired last cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= cmd_fire_s;
    end
  end

  ram_read_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push_s),
    .push_data (ram_rd_data),
    .pop       (fifo_pop_s),
    .count     (fifo_count_s),
    .head      (fifo_head_s)
  );

  assign cmd_ready   = cmd_ready_s;
  assign ram_rd_en   = cmd_fire_s;
  assign ram_rd_addr = cmd_addr;
  assign rsp_valid   = rsp_valid_s;
  assign rsp_data    = rsp_data_s;

endmodule

// File: tb/tb_ram_read_streamer.sv
// Randomized self-checking bench: RAM model plus an in-order expected-data queue.
module tb_ram_read_streamer;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] rsp_log [$];
  int            err_cnt;
  int            chk_cnt;
  int            cmd_acc;
  int            rsp_cnt;

  ram_read_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered RAM read port; output is scrambled when not enabled.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    else           ram_rd_data <= $urandom;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic exp_valid, exp_ready, cmd_fire, rsp_fire;
    @(negedge clk);
    exp_valid = (exp_q.size() != 0);
    exp_ready = resetn && ((exp_q.size() < 2) || (exp_valid && rsp_ready));
    check_eq("rsp_valid", rsp_valid, exp_valid);
    check_eq("cmd_ready", cmd_ready, exp_ready);
    check_eq("ram_rd_en", ram_rd_en, cmd_valid && exp_ready);
    if (cmd_valid) check_eq("ram_rd_addr", ram_rd_addr, cmd_addr);
    if (exp_valid) check_eq("rsp_data", rsp_data, exp_q[0]);
    cmd_fire = cmd_valid && exp_ready;
    rsp_fire = exp_valid && rsp_ready;
    @(posedge clk);
    if (rsp_fire) begin
      rsp_log.push_back(exp_q[0]);
      void'(exp_q.pop_front());
      rsp_cnt++;
    end
    if (cmd_fire) begin
      exp_q.push_back(mem[cmd_addr]);
      cmd_acc++;
    end
    if (exp_q.size() > 2) check_eq("occupancy", exp_q.size(), 2);
    #1;
  endtask

  initial begin
    logic [DW-1:0] hold_val;
    err_cnt = 0; chk_cnt = 0; cmd_acc = 0; rsp_cnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[5] = 32'hDEAD_BEEF;
    resetn = 1'b0; cmd_valid = 1'b1; cmd_addr = 10'd5; rsp_ready = 1'b1;

    // Reset state with a command already presented.
    #12;
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("rst_ram_rd_en", ram_rd_en, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single read, accepted at the first edge after reset release.
    cycle();
    cmd_valid = 1'b0;
    check_eq("single_acc", cmd_acc, 1);
    check_eq("single_valid", rsp_valid, 1'b1);
    check_eq("single_data", rsp_data, 32'hDEAD_BEEF);
    cycle();
    check_eq("single_rsp", rsp_cnt, 1);
    cycle();

    // Streaming 0..15 back-to-back at full rate.
    cmd_acc = 0; rsp_cnt = 0; rsp_log.delete();
    for (int a = 0; a < 16; a++) begin
      cmd_valid = 1'b1; cmd_addr = AW'(a);
      cycle();
    end
    cmd_valid = 1'b0;
    cycle();
    check_eq("stream_acc", cmd_acc, 16);
    check_eq("stream_rsp", rsp_cnt, 16);
    for (int a = 0; a < 16 && a < rsp_log.size(); a++) check_eq("stream_order", rsp_log[a], mem[a]);

    // Backpressure: only two of three commands fit while stalled.
    cmd_acc = 0; rsp_cnt = 0; rsp_log.delete();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 10'd1; cycle();
    cmd_addr = 10'd2; cycle();
    cmd_addr = 10'd3;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("bp_acc", cmd_acc, 2);
    check_eq("bp_cmd_ready", cmd_ready, 1'b0);
    check_eq("bp_hold", rsp_data, mem[1]);
    rsp_ready = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("bp_acc3", cmd_acc, 3);
    check_eq("bp_rsp", rsp_cnt, 3);
    for (int i = 0; i < 3 && i < rsp_log.size(); i++) check_eq("bp_order", rsp_log[i], mem[i+1]);

    // Random stall traffic; the model checks every cycle.
    cmd_acc = 0; rsp_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      cycle();
      hold_val = rsp_data;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("rand_drained", exp_q.size(), 0);
    check_eq("rand_balance", rsp_cnt, cmd_acc);

    // Reset mid-stream with the buffer full.
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_addr = 10'd7;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("pre_rst_occ", exp_q.size(), 2);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("arst_rsp_valid", rsp_valid, 1'b0);
    check_eq("arst_cmd_ready", cmd_ready, 1'b0);
    check_eq("arst_ram_rd_en", ram_rd_en, 1'b0);
    exp_q.delete();
    cycle();
    resetn = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 10'd9; rsp_ready = 1'b1;
    rsp_cnt = 0; rsp_log.delete();
    cycle();
    cmd_valid = 1'b0;
    check_eq("post_rst_data", rsp_data, mem[9]);
    for (int i = 0; i < 3; i++) cycle();
    check_eq("post_rst_rsp", rsp_cnt, 1);
    if (rsp_log.size() > 0) check_eq("post_rst_log", rsp_log[0], mem[9]);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
